// File: rtl/mcpu_core.sv
// Multicycle RV32I-subset core with one shared req/ready memory port for fetch and data.
// Optional feature: define MCPU_HALT_ON_ILLEGAL_EN to make illegal instructions stop the core.
module mcpu_core #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int unsigned NREGS    = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc_o,
    output logic [31:0] result,
    output logic        retire,
    output logic        halted
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXEC_R, S_EXEC_I, S_ALUWB, S_BEQ, S_JAL, S_ILLEGAL
    } state_t;

    typedef enum logic [2:0] {C_MEM, C_R, C_I, C_BEQ, C_JAL, C_ILL} iclass_t;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, old_pc_q, ir_q, a_q, b_q, alu_out_q, data_q, result_q;
    logic [31:0] regs [32];

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_j;
    iclass_t     iclass;
    alu_op_t     alu_op;
    logic [31:0] alu_b, alu_y, diff, rs1_val, rs2_val, wb_val;
    logic        eq, wb_en;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];

    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    // x0 and indices beyond the implemented register count are not storage
    function automatic logic reg_ok(input logic [4:0] idx);
        return (idx != 5'd0) && ((NREGS == 32) || !idx[4]);
    endfunction

    // Instruction classification and ALU operation select
    always_comb begin
        iclass = C_ILL;
        alu_op = ALU_ADD;
        case (opcode)
            OP_LOAD, OP_STORE: if (funct3 == 3'b010) iclass = C_MEM;
            OP_R: begin
                iclass = C_R;
                case ({funct7, funct3})
                    10'b0000000_000: alu_op = ALU_ADD;
                    10'b0100000_000: alu_op = ALU_SUB;
                    10'b0000000_111: alu_op = ALU_AND;
                    10'b0000000_110: alu_op = ALU_OR;
                    10'b0000000_010: alu_op = ALU_SLT;
                    default:         iclass = C_ILL;
                endcase
            end
            OP_I: begin
                iclass = C_I;
                case (funct3)
                    3'b000:  alu_op = ALU_ADD;
                    3'b111:  alu_op = ALU_AND;
                    3'b110:  alu_op = ALU_OR;
                    3'b010:  alu_op = ALU_SLT;
                    default: iclass = C_ILL;
                endcase
            end
            OP_BR:   if (funct3 == 3'b000) iclass = C_BEQ;
            OP_JAL:  iclass = C_JAL;
            default: iclass = C_ILL;
        endcase
    end

    always_comb begin
        alu_b = (state_q == S_EXEC_I) ? imm_i : b_q;
        case (alu_op)
            ALU_ADD: alu_y = a_q + alu_b;
            ALU_SUB: alu_y = a_q - alu_b;
            ALU_AND: alu_y = a_q & alu_b;
            ALU_OR:  alu_y = a_q | alu_b;
            ALU_SLT: alu_y = {31'd0, $signed(a_q) < $signed(alu_b)};
            default: alu_y = a_q + alu_b;
        endcase
    end

    assign diff    = a_q - b_q;
    assign eq      = (diff == 32'd0);
    assign rs1_val = reg_ok(rs1) ? regs[rs1] : 32'd0;
    assign rs2_val = reg_ok(rs2) ? regs[rs2] : 32'd0;
    assign wb_en   = !rst && ((state_q == S_ALUWB) || (state_q == S_MEMWB));
    assign wb_val  = (state_q == S_MEMWB) ? data_q : alu_out_q;
    assign result  = wb_en ? wb_val : result_q;
    assign pc_o    = (state_q == S_FETCH) ? pc_q : old_pc_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Next state and memory/retire outputs; rst masks everything so an aborted access vanishes
    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = alu_out_q;
        mem_wdata = b_q;
        retire    = 1'b0;
        halted    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (iclass)
                    C_MEM:   state_d = S_MEMADR;
                    C_R:     state_d = S_EXEC_R;
                    C_I:     state_d = S_EXEC_I;
                    C_BEQ:   state_d = S_BEQ;
                    C_JAL:   state_d = S_JAL;
                    default: state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                mem_req = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC_R, S_EXEC_I: state_d = S_ALUWB;
            S_ALUWB: begin
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_BEQ: begin
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: state_d = S_ALUWB;
            S_ILLEGAL: begin
`ifdef MCPU_HALT_ON_ILLEGAL_EN
                halted  = 1'b1;
                state_d = S_ILLEGAL;
`else
                retire  = 1'b1;
                state_d = S_FETCH;
`endif
            end
            default: state_d = S_FETCH;
        endcase
        if (rst) begin
            mem_req = 1'b0;
            retire  = 1'b0;
            halted  = 1'b0;
        end
    end

    // Datapath registers; PC already points at OldPC+4 after fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            old_pc_q  <= RESET_PC;
            ir_q      <= 32'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            alu_out_q <= 32'd0;
            data_q    <= 32'd0;
            result_q  <= 32'd0;
        end else begin
            result_q <= result;
            case (state_q)
                S_FETCH: if (mem_ready) begin
                    ir_q     <= mem_rdata;
                    old_pc_q <= pc_q;
                    pc_q     <= pc_q + 32'd4;
                end
                S_DECODE: begin
                    a_q       <= rs1_val;
                    b_q       <= rs2_val;
                    alu_out_q <= old_pc_q + imm_b;
                end
                S_MEMADR:           alu_out_q <= a_q + ((opcode == OP_STORE) ? imm_s : imm_i);
                S_MEMREAD:          if (mem_ready) data_q <= mem_rdata;
                S_EXEC_R, S_EXEC_I: alu_out_q <= alu_y;
                S_BEQ:              if (eq) pc_q <= alu_out_q;
                S_JAL: begin
                    pc_q      <= old_pc_q + imm_j;
                    alu_out_q <= old_pc_q + 32'd4;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (wb_en && reg_ok(rd)) begin
            regs[rd] <= wb_val;
        end
    end

endmodule

// File: tb/tb_mcpu_core.sv
// Self-checking bench for mcpu_core: wait-state memory model plus an instruction-level reference model.
module tb_mcpu_core;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ready, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_o, result;

    int checks = 0;
    int errors = 0;

    mcpu_core #(.RESET_PC(RESET_PC), .NREGS(32)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc_o(pc_o), .result(result), .retire(retire), .halted(halted)
    );

    always #5 clk = ~clk;

    // Memory: code at RESET_PC, data near address 0, programmable wait states
    logic [31:0] imem [64];
    logic [31:0] dmem [64];
    logic [31:0] dmem_init [64];
    int          wait_states = 0;
    int          wcnt;
    logic [5:0]  iidx, didx;

    always_comb begin
        iidx      = 6'((mem_addr - RESET_PC) >> 2);
        didx      = 6'(mem_addr >> 2);
        mem_ready = mem_req && (wcnt >= wait_states);
        mem_rdata = (mem_addr >= RESET_PC) ? imem[iidx] : dmem[didx];
    end

    always @(posedge clk) begin
        if (rst) begin
            wcnt <= 0;
            for (int i = 0; i < 64; i++) dmem[i] <= dmem_init[i];
        end else if (mem_req && mem_ready) begin
            wcnt <= 0;
            if (mem_we) dmem[didx] <= mem_wdata;
        end else if (mem_req) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    // Encoders
    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return 32'((f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 51);
    endfunction
    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
        return 32'(((imm & 4095) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op);
    endfunction
    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        return 32'((((imm >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12) | ((imm & 31) << 7) | 35);
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1);
        return 32'((((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15)
                   | (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7) | 99);
    endfunction
    function automatic logic [31:0] enc_j(input int imm, input int rd);
        return 32'((((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21) | (((imm >> 11) & 1) << 20)
                   | (((imm >> 12) & 255) << 12) | (rd << 7) | 111);
    endfunction
    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return enc_i(imm, rs1, 0, rd, 19);
    endfunction
    function automatic logic [31:0] lw(input int rd, input int rs1, input int imm);
        return enc_i(imm, rs1, 2, rd, 3);
    endfunction

    // Instruction-level reference model
    logic [31:0] m_regs [32];
    logic [31:0] m_dmem [64];
    logic [31:0] m_pc;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        for (int i = 0; i < 64; i++) m_dmem[i] = dmem_init[i];
        m_pc = RESET_PC;
    endtask

    task automatic model_step(input logic [31:0] inst, output bit wr, output logic [31:0] val,
                              output int base, output int acc, output bit st,
                              output logic [31:0] sa, output logic [31:0] sd, output bit ill);
        int ii, opc, rd, f3, rs1, rs2, f7, imm_i, imm_s, imm_b, imm_j;
        logic [31:0] x, y, npc, ea;
        ii = int'(inst);
        opc = ii & 127; rd = (ii >> 7) & 31; f3 = (ii >> 12) & 7;
        rs1 = (ii >> 15) & 31; rs2 = (ii >> 20) & 31; f7 = (ii >> 25) & 127;
        imm_i = ii >>> 20;
        imm_s = ((ii >>> 25) * 32) + ((ii >> 7) & 31);
        imm_b = ((ii >>> 31) * 4096) + (((ii >> 7) & 1) * 2048) + (((ii >> 25) & 63) * 32) + (((ii >> 8) & 15) * 2);
        imm_j = ((ii >>> 31) * 1048576) + (((ii >> 12) & 255) * 4096) + (((ii >> 20) & 1) * 2048) + (((ii >> 21) & 1023) * 2);
        x = m_regs[rs1]; y = m_regs[rs2];
        wr = 0; val = 0; base = 4; acc = 1; st = 0; sa = 0; sd = 0; ill = 0;
        npc = m_pc + 32'd4;
        case (opc)
            3: if (f3 == 2) begin
                ea = x + 32'(imm_i); val = m_dmem[ea[7:2]]; wr = 1; base = 5; acc = 2;
            end else ill = 1;
            35: if (f3 == 2) begin
                st = 1; sa = x + 32'(imm_s); sd = y; m_dmem[sa[7:2]] = y; acc = 2;
            end else ill = 1;
            51: begin
                wr = 1;
                if (f7 == 0 && f3 == 0) val = x + y;
                else if (f7 == 32 && f3 == 0) val = x - y;
                else if (f7 == 0 && f3 == 7) val = x & y;
                else if (f7 == 0 && f3 == 6) val = x | y;
                else if (f7 == 0 && f3 == 2) val = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
                else ill = 1;
            end
            19: begin
                wr = 1;
                if (f3 == 0) val = x + 32'(imm_i);
                else if (f3 == 7) val = x & 32'(imm_i);
                else if (f3 == 6) val = x | 32'(imm_i);
                else if (f3 == 2) val = ($signed(x) < imm_i) ? 32'd1 : 32'd0;
                else ill = 1;
            end
            99: if (f3 == 0) begin
                base = 3;
                if (x == y) npc = m_pc + 32'(imm_b);
            end else ill = 1;
            111: begin wr = 1; val = m_pc + 32'd4; npc = m_pc + 32'(imm_j); end
            default: ill = 1;
        endcase
        if (ill) begin wr = 0; base = 3; end
        if (wr && rd != 0) m_regs[rd] = val;
        m_pc = npc;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) begin imem[i] = 32'h0000_0013; dmem_init[i] = 32'd0; end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %b want 0", mem_req); end
        checks++; if (retire !== 1'b0) begin errors++; $display("FAIL rst_retire got %b want 0", retire); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL rst_result got %h want 0", result); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b want 0", halted); end
        rst = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== RESET_PC) begin
            errors++; $display("FAIL first_fetch got req=%b we=%b addr=%h want 1 0 %h", mem_req, mem_we, mem_addr, RESET_PC);
        end
    endtask

    // Run n instructions from the current model state, checking each retirement
    task automatic run_body(input int n, input int waits, input int first_cyc);
        logic [31:0] inst, val, sa, sd, old;
        bit wr, st, ill, got;
        int base, acc, cyc, rd;
        for (int k = 0; k < n; k++) begin
            inst = imem[6'((m_pc - RESET_PC) >> 2)];
            rd   = int'(inst[11:7]);
            old  = m_pc;
            model_step(inst, wr, val, base, acc, st, sa, sd, ill);
            cyc  = (k == 0) ? first_cyc : 0;
            got  = 0;
`ifdef MCPU_HALT_ON_ILLEGAL_EN
            if (ill) begin
                while (cyc < 50 && !got) begin @(negedge clk); cyc++; if (halted === 1'b1) got = 1; end
                checks++;
                if (!got || cyc != 3 + waits) begin
                    errors++; $display("FAIL halt_latency got %0d want %0d", cyc, 3 + waits);
                end
                for (int j = 0; j < 10; j++) begin
                    @(negedge clk);
                    checks++;
                    if (mem_req !== 1'b0 || retire !== 1'b0 || halted !== 1'b1) begin
                        errors++; $display("FAIL halt_hold got req=%b ret=%b halt=%b want 0 0 1", mem_req, retire, halted);
                    end
                end
                return;
            end
`endif
            while (cyc < 300 && !got) begin @(negedge clk); cyc++; if (retire === 1'b1) got = 1; end
            checks++;
            if (!got) begin errors++; $display("FAIL retire_timeout at pc %h", old); return; end
            checks++;
            if (cyc != base + waits * acc) begin
                errors++; $display("FAIL cycles pc %h got %0d want %0d", old, cyc, base + waits * acc);
            end
            checks++;
            if (pc_o !== old) begin errors++; $display("FAIL pc_o_retire got %h want %h", pc_o, old); end
            if (wr && rd != 0) begin
                checks++;
                if (result !== val) begin errors++; $display("FAIL result pc %h got %h want %h", old, result, val); end
            end
            if (st) begin
                checks++;
                if (mem_we !== 1'b1 || mem_addr !== sa || mem_wdata !== sd) begin
                    errors++; $display("FAIL store got we=%b a=%h d=%h want 1 %h %h", mem_we, mem_addr, mem_wdata, sa, sd);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (pc_o !== m_pc) begin errors++; $display("FAIL next_pc got %h want %h", pc_o, m_pc); end
    endtask

    task automatic run_prog(input int n, input int waits);
        wait_states = waits;
        model_reset();
        reset_dut();
        run_body(n, waits, 1);
    endtask

    task automatic test_reset();
        clear_prog();
        model_reset();
        reset_dut();
        checks++;
        if (pc_o !== RESET_PC) begin errors++; $display("FAIL reset_pc got %h want %h", pc_o, RESET_PC); end
    endtask

    task automatic test_alu_seq();
        clear_prog();
        imem[0] = addi(8, 0, 6);
        imem[1] = addi(9, 0, 4);
        imem[2] = enc_r(0, 9, 8, 0, 18);
        imem[3] = enc_r(32, 9, 8, 0, 19);
        run_prog(4, 0);
    endtask

    task automatic test_mem_wait();
        clear_prog();
        imem[0] = addi(8, 0, 6);
        imem[1] = addi(9, 0, 4);
        imem[2] = enc_r(0, 9, 8, 0, 18);
        imem[3] = enc_s(8, 18, 0);
        imem[4] = lw(20, 0, 8);
        imem[5] = enc_r(0, 0, 20, 0, 23);
        run_prog(6, 2);
        checks++;
        if (dmem[2] !== 32'd10) begin errors++; $display("FAIL mem_word8 got %h want 0000000a", dmem[2]); end
    endtask

    task automatic test_branch();
        clear_prog();
        imem[0] = addi(8, 0, 6);
        imem[1] = addi(9, 0, 4);
        imem[2] = enc_b(8, 8, 8);
        imem[3] = addi(10, 0, 1);
        imem[4] = enc_b(8, 9, 8);
        imem[5] = addi(11, 0, 2);
        imem[6] = enc_j(-12, 1);
        run_prog(9, 0);
    endtask

    task automatic test_mixed();
        clear_prog();
        imem[0]  = addi(8, 0, -1);
        imem[1]  = addi(9, 0, 4);
        imem[2]  = enc_r(0, 9, 8, 7, 12);
        imem[3]  = enc_r(0, 9, 8, 6, 13);
        imem[4]  = enc_r(0, 9, 8, 2, 14);
        imem[5]  = enc_r(0, 9, 8, 0, 0);
        imem[6]  = enc_r(0, 0, 0, 0, 15);
        imem[7]  = enc_i(240, 8, 7, 16, 19);
        imem[8]  = enc_i(-8, 9, 6, 17, 19);
        imem[9]  = enc_i(5, 9, 2, 24, 19);
        imem[10] = enc_i(-2, 8, 2, 25, 19);
        run_prog(11, 1);
    endtask

    task automatic test_illegal();
        clear_prog();
        imem[0] = addi(8, 0, 5);
        imem[1] = 32'hFFFF_FFFF;
        imem[2] = addi(9, 8, 7);
        run_prog(3, 0);
    endtask

    task automatic test_reset_mid_read();
        bit found;
        clear_prog();
        imem[0]      = lw(20, 0, 8);
        dmem_init[2] = 32'h0000_0055;
        wait_states  = 20;
        model_reset();
        reset_dut();
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1 && mem_we === 1'b0 && mem_addr === 32'd8) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL memread_stall_seen got 0 want 1"); return; end
        rst = 1'b1;
        @(negedge clk);
        imem[0]     = enc_r(0, 0, 20, 0, 21);
        wait_states = 0;
        rst = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== RESET_PC) begin
            errors++; $display("FAIL abort_refetch got req=%b addr=%h want 1 %h", mem_req, mem_addr, RESET_PC);
        end
        model_reset();
        run_body(1, 0, 1);
    endtask

    function automatic logic [31:0] rand_inst();
        int kind, rd, r1, r2, imm;
        kind = int'($urandom_range(0, 10));
        rd   = int'($urandom_range(0, 15));
        r1   = int'($urandom_range(0, 15));
        r2   = int'($urandom_range(0, 15));
        imm  = int'($urandom_range(0, 4095)) - 2048;
        case (kind)
            0: return enc_r(0, r2, r1, 0, rd);
            1: return enc_r(32, r2, r1, 0, rd);
            2: return enc_r(0, r2, r1, 7, rd);
            3: return enc_r(0, r2, r1, 6, rd);
            4: return enc_r(0, r2, r1, 2, rd);
            5: return enc_i(imm, r1, 0, rd, 19);
            6: return enc_i(imm, r1, 7, rd, 19);
            7: return enc_i(imm, r1, 6, rd, 19);
            8: return enc_i(imm, r1, 2, rd, 19);
            9: return enc_s(4 * int'($urandom_range(0, 15)), r2, 0);
            default: return lw(rd, 0, 4 * int'($urandom_range(0, 15)));
        endcase
    endfunction

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            clear_prog();
            for (int i = 0; i < 24; i++) imem[i] = rand_inst();
            for (int i = 0; i < 16; i++) dmem_init[i] = $urandom;
            run_prog(24, int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        test_reset();
        test_alu_seq();
        test_mem_wait();
        test_branch();
        test_mixed();
        test_illegal();
        test_reset_mid_read();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
